// File: rtl/rs_pkg.sv
// Shared types for the RS command sequencer: FSM states, command kinds, expected feedback.
// Pure declarations; no latency or flow control of its own.
package rs_pkg;

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;
  typedef enum logic {CMD_SET, CMD_RST} cmd_t;

  // Feedback packed as {q1, q2}
  localparam logic [1:0] FB_SET = 2'b10;
  localparam logic [1:0] FB_RST = 2'b01;

  function automatic logic [1:0] exp_fb(input cmd_t c);
    return (c == CMD_SET) ? FB_SET : FB_RST;
  endfunction

endpackage

// File: rtl/rs_cmd_sequencer_if.sv
// Button, flip-flop feedback and command/status bundle of the RS command sequencer.
// Plain wires; no latency, no backpressure (commands are self-timed pulses).
interface rs_cmd_sequencer_if;

  logic       set_req;
  logic       rst_req;
  logic       q1_fb;
  logic       q2_fb;
  logic       R;
  logic       S;
  logic       busy;
  logic       conflict;
  logic       err;
  logic [7:0] err_cnt;

  modport master (
    output set_req, rst_req, q1_fb, q2_fb,
    input  R, S, busy, conflict, err, err_cnt
  );

  modport slave (
    input  set_req, rst_req, q1_fb, q2_fb,
    output R, S, busy, conflict, err, err_cnt
  );

endinterface

// File: rtl/rs_debounce.sv
// Two-flop synchronizer, stability debounce and rising-edge detect for one raw button.
// Level follows input DEB_CYCLES cycles after sync; rise is a registered 1-cycle pulse; no backpressure.
module rs_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      // Any cycle agreeing with the current level restarts the stability count
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= s2;
        rise  <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_cmd_sequencer.sv
// Turns debounced set/reset buttons into exclusive, timed R/S pulses and checks Q1/Q2 afterwards.
// R/S rise 4+DEB_CYCLES cycles after a clean press; requests during a command queue (one per type).
module rs_cmd_sequencer
  import rs_pkg::*;
#(
  parameter int DEB_CYCLES    = 4,
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input logic              clk,
  input logic              rst_n,
  rs_cmd_sequencer_if.slave bus
);

  logic       set_lvl, set_rise;
  logic       rst_lvl, rst_rise;
  logic       unused_lvl;
  logic       pend_s, pend_r;
  logic       clr_s, clr_r;
  logic       r_q, s_q, busy_q, conflict_q, err_q;
  logic [7:0] err_cnt_q;
  logic [7:0] tcnt;
  state_t     state;
  cmd_t       cmd;

  rs_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
    .clk(clk), .rst_n(rst_n), .din(bus.set_req), .level(set_lvl), .rise(set_rise)
  );

  rs_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_rst (
    .clk(clk), .rst_n(rst_n), .din(bus.rst_req), .level(rst_lvl), .rise(rst_rise)
  );

  assign unused_lvl = set_lvl ^ rst_lvl;

  // Reset has priority both in IDLE arbitration and on simultaneous events: Q1=0 is the safe state
  assign clr_r = (state == IDLE) && pend_r;
  assign clr_s = (state == IDLE) && !pend_r && pend_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cmd        <= CMD_SET;
      tcnt       <= '0;
      pend_s     <= 1'b0;
      pend_r     <= 1'b0;
      r_q        <= 1'b0;
      s_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      conflict_q <= set_rise & rst_rise;
      pend_r     <= (pend_r & ~clr_r) | rst_rise;
      pend_s     <= (pend_s & ~clr_s) | (set_rise & ~rst_rise);

      case (state)
        IDLE: begin
          if (pend_r || pend_s) begin
            state  <= DRIVE;
            cmd    <= pend_r ? CMD_RST : CMD_SET;
            r_q    <= pend_r;
            s_q    <= !pend_r;
            busy_q <= 1'b1;
            tcnt   <= '0;
          end
        end
        DRIVE: begin
          if (tcnt == 8'(PULSE_CYCLES - 1)) begin
            state <= SETTLE;
            r_q   <= 1'b0;
            s_q   <= 1'b0;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        SETTLE: begin
          if (tcnt == 8'(SETTLE_CYCLES - 1)) begin
            state <= CHECK;
            tcnt  <= '0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        CHECK: begin
          if ({bus.q1_fb, bus.q2_fb} != exp_fb(cmd)) begin
            err_q <= 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
          end
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.R        = r_q;
  assign bus.S        = s_q;
  assign bus.busy     = busy_q;
  assign bus.conflict = conflict_q;
  assign bus.err      = err_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_rs_cmd_sequencer.sv
// Scoreboard bench: stimulus queues expected commands, a negedge monitor checks each completed command.
// Includes a behavioural clocked RS flip-flop driving the feedback, with a stuck-at-0 fault switch.
module tb_rs_cmd_sequencer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rs_cmd_sequencer_if bus ();

  rs_cmd_sequencer #(
    .DEB_CYCLES(4), .PULSE_CYCLES(2), .SETTLE_CYCLES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // NOR-style RS flip-flop model; fault forces both outputs low
  logic ffq   = 1'b0;
  bit   fault = 1'b0;
  always @(posedge clk) begin
    if (bus.S) ffq <= 1'b1;
    else if (bus.R) ffq <= 1'b0;
  end
  assign bus.q1_fb = fault ? 1'b0 : ffq;
  assign bus.q2_fb = fault ? 1'b0 : ~ffq;

  typedef struct {
    bit is_set;
    int start;
    bit err;
    int cnt;
    bit fault;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;
  int   m_cnt = 0;
  bit   m_err = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic expect_cmd(input bit is_set, input int start);
    exp_t x;
    if (fault) begin
      m_err = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
    x.is_set = is_set;
    x.start  = start;
    x.err    = m_err;
    x.cnt    = m_cnt;
    x.fault  = fault;
    sbq.push_back(x);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor state
  bit         p_busy = 1'b0, p_conf = 1'b0;
  int         s_cnt, r_cnt, blen, st, ovl;
  logic [1:0] lq;
  int         busy_rises = 0, conf_cnt = 0, conf_wide = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_busy = 1'b0;
      p_conf = 1'b0;
    end else begin
      if (bus.R && bus.S) ovl++;
      if (bus.conflict) begin
        conf_cnt++;
        if (p_conf) conf_wide++;
      end
      p_conf = bus.conflict;
      if (bus.busy && !p_busy) begin
        busy_rises++;
        st = cyc; s_cnt = 0; r_cnt = 0; blen = 0; ovl = 0;
      end
      if (bus.busy) begin
        blen++;
        s_cnt += int'(bus.S);
        r_cnt += int'(bus.R);
        lq = {bus.q1_fb, bus.q2_fb};
      end
      if (!bus.busy && p_busy) begin
        if (sbq.size() == 0) begin
          chk("sb_has_expected", sbq.size(), 1);
        end else begin
          e = sbq.pop_front();
          chk("s_pulse_cycles", s_cnt, e.is_set ? 2 : 0);
          chk("r_pulse_cycles", r_cnt, e.is_set ? 0 : 2);
          chk("busy_len", blen, 5);
          chk("start_cycle", st, e.start);
          chk("err", int'(bus.err), int'(e.err));
          chk("err_cnt", int'(bus.err_cnt), e.cnt);
          chk("fb_at_check", int'(lq), e.fault ? 0 : (e.is_set ? 2 : 1));
          chk("r_and_s_overlap", ovl, 0);
        end
      end
      p_busy = bus.busy;
    end
  end

  int n, br, cc;

  initial begin
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;

    // Reset state
    tick(2);
    chk("reset_outputs", int'({bus.R, bus.S, bus.busy, bus.conflict, bus.err, bus.err_cnt}), 0);
    rst_n = 1'b1;
    tick(3);
    chk("idle_after_reset", int'({bus.R, bus.S, bus.busy, bus.conflict, bus.err, bus.err_cnt}), 0);

    // Clean set press
    bus.set_req = 1'b1;
    expect_cmd(1'b1, cyc + 8);
    tick(20);
    bus.set_req = 1'b0;
    tick(10);

    // Bouncing press settling high
    for (int i = 0; i < 6; i++) begin
      bus.set_req = (i % 2 == 0);
      tick(1);
    end
    bus.set_req = 1'b1;
    expect_cmd(1'b1, cyc + 8);
    tick(20);
    bus.set_req = 1'b0;
    tick(10);

    // Three-cycle glitch must not produce a command
    br = busy_rises;
    bus.set_req = 1'b1;
    tick(3);
    bus.set_req = 1'b0;
    tick(20);
    chk("glitch_no_cmd", busy_rises, br);

    // Simultaneous set and reset: reset wins, one conflict pulse
    cc = conf_cnt;
    bus.set_req = 1'b1;
    bus.rst_req = 1'b1;
    expect_cmd(1'b0, cyc + 8);
    tick(20);
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;
    tick(10);
    chk("conflict_pulses", conf_cnt - cc, 1);

    // Requests arriving while busy are queued and served in priority order
    n = cyc;
    bus.set_req = 1'b1;
    expect_cmd(1'b1, n + 8);
    expect_cmd(1'b0, n + 14);
    expect_cmd(1'b1, n + 20);
    tick(2);
    bus.rst_req = 1'b1;
    tick(3);
    bus.set_req = 1'b0;
    tick(5);
    bus.set_req = 1'b1;
    tick(20);
    bus.set_req = 1'b0;
    bus.rst_req = 1'b0;
    tick(15);

    // Stuck feedback: error count climbs then saturates
    fault = 1'b1;
    for (int k = 0; k < 300; k++) begin
      bus.set_req = 1'b1;
      expect_cmd(1'b1, cyc + 8);
      tick(14);
      bus.set_req = 1'b0;
      tick(8);
    end
    chk("err_cnt_saturated", int'(bus.err_cnt), 255);
    chk("err_sticky", int'(bus.err), 1);
    fault = 1'b0;

    // Reset asserted mid-DRIVE drops S immediately and clears status
    bus.set_req = 1'b1;
    tick(8);
    chk("s_before_reset", int'(bus.S), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", int'({bus.R, bus.S, bus.busy, bus.conflict, bus.err, bus.err_cnt}), 0);
    bus.set_req = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    br = busy_rises;
    tick(30);
    chk("no_cmd_after_reset", busy_rises, br);

    bus.set_req = 1'b1;
    expect_cmd(1'b1, cyc + 8);
    tick(20);
    bus.set_req = 1'b0;
    tick(10);

    chk("scoreboard_drained", sbq.size(), 0);
    chk("conflict_width", conf_wide, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
